// File: rtl/ad7606_emu.sv
// Behavioural AD7606 parallel-bus device model: answers CONVST/RD with a BUSY
// window and a deterministic per-channel ramp, for loopback without the real ADC.

module ad7606_emu_lane #(
  parameter int          K       = 0,
  parameter logic [15:0] CH_STEP = 16'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] base,
  output logic [15:0] word
);
  // Channel offset is a per-lane constant, so the latch is a single adder.
  localparam logic [31:0] PROD = K * CH_STEP;
  localparam logic [15:0] OFS  = PROD[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       word <= '0;
    else if (load) word <= base + OFS;
  end
endmodule

module ad7606_emu #(
  parameter int          BUSY_CYCLES = 200,
  parameter int          CH_NUM      = 8,
  parameter logic [15:0] CH_STEP     = 16'h0100,
  parameter logic [15:0] RAMP_INC    = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        conv,
  input  logic        rd_n,
  output logic        busy,
  output logic [15:0] data_out,
  output logic        frstdata,
  output logic        conv_err
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_READ} state_t;

  localparam logic [15:0] CNT_LAST = 16'(BUSY_CYCLES - 1);
  localparam logic [2:0]  PTR_LAST = 3'(CH_NUM - 1);

  state_t            state, state_n;
  logic              conv_q, rd_q;
  logic [15:0]       base, cnt;
  logic [2:0]        ch_ptr;
  logic [7:0][15:0]  sample;
  logic              conv_rise, rd_fall;
  logic              start, done, err, take, idle_rd;

  assign conv_rise = conv & ~conv_q;
  assign rd_fall   = rd_q & ~rd_n;

  for (genvar k = 0; k < 8; k++) begin : g_lane
    if (k < CH_NUM) begin : g_on
      ad7606_emu_lane #(.K(k), .CH_STEP(CH_STEP)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .load (start),
        .base (base),
        .word (sample[k])
      );
    end else begin : g_off
      assign sample[k] = '0;
    end
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    take    = 1'b0;
    idle_rd = 1'b0;
    case (state)
      S_IDLE: begin
        if (conv_rise) begin
          start   = 1'b1;
          state_n = S_BUSY;
        end else if (rd_fall) begin
          idle_rd = 1'b1;
        end
      end
      S_BUSY: begin
        err = conv_rise;
        if (cnt == CNT_LAST) begin
          done    = 1'b1;
          state_n = S_READ;
        end
      end
      S_READ: begin
        // A new CONVST aborts the readout and beats a coincident RD edge.
        if (conv_rise) begin
          start   = 1'b1;
          state_n = S_BUSY;
        end else if (rd_fall) begin
          take = 1'b1;
          if (ch_ptr == PTR_LAST) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      conv_q   <= 1'b0;
      rd_q     <= 1'b1;
      base     <= '0;
      cnt      <= '0;
      ch_ptr   <= '0;
      busy     <= 1'b0;
      data_out <= '0;
      frstdata <= 1'b0;
      conv_err <= 1'b0;
    end else begin
      state    <= state_n;
      conv_q   <= conv;
      rd_q     <= rd_n;
      conv_err <= err;
      if (start) begin
        base <= base + RAMP_INC;
        busy <= 1'b1;
        cnt  <= '0;
      end else if (done) begin
        busy   <= 1'b0;
        ch_ptr <= '0;
      end else if (state == S_BUSY) begin
        cnt <= cnt + 16'd1;
      end
      if (take) begin
        data_out <= sample[ch_ptr];
        frstdata <= (ch_ptr == 3'd0);
        ch_ptr   <= ch_ptr + 3'd1;
      end
      if (idle_rd) frstdata <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ad7606_emu.sv
// Directed + randomized checks of ad7606_emu against a ramp model: default
// instance for timing/readout, a second instance for modulo-2^16 wrap.

module tb_ad7606_emu;
  logic        clk = 1'b0;
  logic        rst, conv, rd_n, sel;
  logic        conv_a, rd_a, conv_b, rd_b;
  logic        busy_a, frst_a, err_a, busy_b, frst_b, err_b;
  logic [15:0] data_a, data_b;
  logic        busy_o, frst_o, err_o;
  logic [15:0] data_o;

  int          n_cmp = 0, n_bad = 0;
  logic [15:0] mbase [2];
  logic [15:0] lat_base, last_word, obs_word;

  always #5 clk = ~clk;

  assign conv_a = conv & ~sel;
  assign rd_a   = rd_n | sel;
  assign conv_b = conv & sel;
  assign rd_b   = rd_n | ~sel;
  assign busy_o = sel ? busy_b : busy_a;
  assign data_o = sel ? data_b : data_a;
  assign frst_o = sel ? frst_b : frst_a;
  assign err_o  = sel ? err_b  : err_a;

  ad7606_emu u_dut_a (
    .clk(clk), .rst(rst), .conv(conv_a), .rd_n(rd_a),
    .busy(busy_a), .data_out(data_a), .frstdata(frst_a), .conv_err(err_a)
  );

  ad7606_emu #(.BUSY_CYCLES(4), .CH_NUM(8), .CH_STEP(16'hF000), .RAMP_INC(16'h8000)) u_dut_b (
    .clk(clk), .rst(rst), .conv(conv_b), .rd_n(rd_b),
    .busy(busy_b), .data_out(data_b), .frstdata(frst_b), .conv_err(err_b)
  );

  function automatic logic [15:0] step_of(input logic s);
    return s ? 16'hF000 : 16'h0100;
  endfunction

  function automatic logic [15:0] inc_of(input logic s);
    return s ? 16'h8000 : 16'h0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a conversion, optionally colliding with an RD edge, injecting an
  // illegal CONVST at busy cycle err_at, and/or wiggling RD during BUSY.
  task automatic start_conv(input int err_at, input bit toggle_rd, input bit with_rd);
    int len, errs;
    logic [15:0] hold;
    @(negedge clk);
    conv = 1'b1;
    if (with_rd) rd_n = 1'b0;
    lat_base   = mbase[sel];
    mbase[sel] = mbase[sel] + inc_of(sel);
    hold = last_word;
    @(negedge clk);
    conv = 1'b0;
    rd_n = 1'b1;
    chk("busy_rise", busy_o, 1);
    if (with_rd) chk("collide_hold", data_o, hold);
    len  = 0;
    errs = 0;
    while (busy_o && len < 1000) begin
      len++;
      conv = (len == err_at);
      if (toggle_rd) rd_n = ~rd_n;
      @(negedge clk);
      if (err_o) errs++;
    end
    conv = 1'b0;
    rd_n = 1'b1;
    chk("busy_len", len, sel ? 4 : 200);
    chk("conv_err_cnt", errs, (err_at > 0) ? 1 : 0);
    if (toggle_rd) chk("busy_rd_hold", data_o, hold);
  endtask

  task automatic rd_word(input int k);
    int lo, hi;
    logic [15:0] exp;
    lo  = $urandom_range(1, 3);
    hi  = $urandom_range(1, 3);
    exp = lat_base + 16'(k) * step_of(sel);
    @(negedge clk);
    rd_n = 1'b0;
    @(negedge clk);
    obs_word = data_o;
    chk($sformatf("word%0d", k), data_o, exp);
    chk($sformatf("frst%0d", k), frst_o, (k == 0));
    last_word = exp;
    repeat (lo - 1) @(negedge clk);
    rd_n = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic read_all(input int n);
    for (int k = 0; k < n; k++) rd_word(k);
  endtask

  task automatic idle_read();
    @(negedge clk);
    rd_n = 1'b0;
    @(negedge clk);
    chk("idle_data", data_o, last_word);
    chk("idle_frst", frst_o, 0);
    rd_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; conv = 1'b0; rd_n = 1'b1; sel = 1'b0;
    mbase[0] = '0; mbase[1] = '0; lat_base = '0; last_word = '0; obs_word = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_frst", frst_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;

    // basic conversion, then ramp advance, extra reads in IDLE
    start_conv(0, 0, 0);
    read_all(8);
    idle_read();
    start_conv(0, 0, 0);
    read_all(8);
    idle_read();

    // illegal CONVST at busy cycle 50, RD wiggled during BUSY
    start_conv(50, 1, 0);
    read_all(8);

    // abort after 3 words, then collision after 2 words
    start_conv(0, 0, 0);
    read_all(3);
    start_conv(0, 0, 0);
    read_all(2);
    start_conv(0, 0, 1);
    read_all(8);

    // randomized partial readouts with aborts
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 8);
      start_conv(0, 0, 0);
      read_all(n);
      if (n == 8) idle_read();
    end

    // reset at busy cycle 100, applied between clock edges
    @(negedge clk);
    conv = 1'b1;
    @(negedge clk);
    conv = 1'b0;
    repeat (99) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_data", data_o, 0);
    chk("midrst_frst", frst_o, 0);
    mbase[0] = '0; mbase[1] = '0; last_word = '0;
    @(negedge clk);
    rst = 1'b0;
    start_conv(0, 0, 0);
    read_all(8);

    // wrap-around instance: bases 0x0000, 0x8000, 0x0000
    sel = 1'b1;
    last_word = '0;
    start_conv(0, 0, 0);
    read_all(8);
    start_conv(0, 0, 0);
    read_all(8);
    start_conv(0, 0, 0);
    rd_word(0);
    rd_word(1);
    chk("wrap_ch1", obs_word, 16'hF000);
    rd_word(2);
    chk("wrap_ch2", obs_word, 16'hE000);
    for (int k = 3; k < 8; k++) rd_word(k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
